// File: rtl/shifter_seq.sv
// ============================================================================
//  Module   : shifter_seq
//  Purpose  : Multi-cycle logarithmic shifter (SLL/ROL/SRL/SRA/ROR) with
//             valid/ready handshakes; optional macro SHIFTER_EARLY_DONE_EN
//             ends the pass once no higher shift-count bits remain.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_seq #(
  parameter int WIDTH          = 16,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_cnt,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_err
);

  localparam int L    = $clog2(WIDTH);
  localparam int G    = (L + ROWS_PER_CYCLE - 1) / ROWS_PER_CYCLE;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam logic [GW-1:0] LAST_G = GW'(G - 1);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [L-1:0]     cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [GW-1:0]    g_q,     g_d;
  logic             sign_q,  sign_d;
  logic             err_q,   err_d;

  logic [WIDTH-1:0] stage [0:L];
  logic [L-1:0]     row_en;

  assign stage[0] = data_q;

  // All L rows are laid out; only those belonging to the current group are enabled.
  for (genvar j = 0; j < L; j++) begin : g_row
    localparam int S = 1 << j;
    logic [WIDTH-1:0] shifted;

    assign row_en[j] = (g_q == GW'(j / ROWS_PER_CYCLE));

    always_comb begin
      shifted = stage[j];
      case (op_q)
        OP_SLL:  shifted = {stage[j][WIDTH-1-S:0], {S{1'b0}}};
        OP_ROL:  shifted = {stage[j][WIDTH-1-S:0], stage[j][WIDTH-1:WIDTH-S]};
        OP_SRL:  shifted = {{S{1'b0}}, stage[j][WIDTH-1:S]};
        OP_SRA:  shifted = {{S{sign_q}}, stage[j][WIDTH-1:S]};
        OP_ROR:  shifted = {stage[j][S-1:0], stage[j][WIDTH-1:S]};
        default: shifted = stage[j];
      endcase
    end

    assign stage[j+1] = (row_en[j] && cnt_q[j] && !err_q) ? shifted : stage[j];
  end

`ifdef SHIFTER_EARLY_DONE_EN
  logic [L-1:0] later_row;
  logic         rest_zero;

  for (genvar j = 0; j < L; j++) begin : g_later
    assign later_row[j] = (g_q < GW'(j / ROWS_PER_CYCLE));
  end

  assign rest_zero = ~|(cnt_q & later_row);
`endif

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    g_d     = g_q;
    sign_d  = sign_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_cnt;
          op_d    = in_op;
          sign_d  = in_data[WIDTH-1];
          err_d   = (in_op > OP_ROR);
          g_d     = '0;
          state_d = BUSY;
`ifdef SHIFTER_EARLY_DONE_EN
          if (in_cnt == '0) state_d = DONE;
`endif
        end
      end
      BUSY: begin
        data_d = stage[L];
        if (g_q == LAST_G) begin
          state_d = DONE;
        end else begin
          g_d = g_q + GW'(1);
`ifdef SHIFTER_EARLY_DONE_EN
          if (rest_zero) state_d = DONE;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      g_q     <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      g_q     <= g_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shifter_seq.sv
// ============================================================================
//  Module   : tb_shifter_seq
//  Purpose  : Scoreboard bench for shifter_seq (16-bit R=1 and 32-bit R=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shifter_seq;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] in_data, out_data;
  logic [3:0]  in_cnt;
  logic [2:0]  in_op;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
  logic [31:0] in_data2, out_data2;
  logic [4:0]  in_cnt2;
  logic [2:0]  in_op2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  shifter_seq #(.WIDTH(16), .ROWS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_cnt(in_cnt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  shifter_seq #(.WIDTH(32), .ROWS_PER_CYCLE(2)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .in_cnt(in_cnt2), .in_op(in_op2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_err(out_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref16(logic [15:0] d, int c, logic [2:0] op);
    logic [31:0] dd;
    dd = {d, d};
    case (op)
      3'd0: return d << c;
      3'd1: begin dd = dd << c; return dd[31:16]; end
      3'd2: return d >> c;
      3'd3: return 16'($signed(d) >>> c);
      3'd4: begin dd = dd >> c; return dd[15:0]; end
      default: return d;
    endcase
  endfunction

  function automatic int exp_lat(int cnt, int l, int r);
    int h;
`ifdef SHIFTER_EARLY_DONE_EN
    if (cnt == 0) return 1;
    h = 0;
    for (int b = 0; b < l; b++) if (cnt[b]) h = b;
    return h / r + 2;
`else
    h = l;
    return (h + r - 1) / r + 1;
`endif
  endfunction

  // Drives one accept on the 16-bit instance and records its expectation.
  task automatic send(input logic [15:0] d, input int c, input logic [2:0] op);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    in_data  = d;
    in_cnt   = 4'(c);
    in_op    = op;
    in_valid = 1'b1;
    e.data = ref16(d, c, op);
    e.err  = (op > 3'd4);
    e.lat  = exp_lat(c, 4, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit rdy_seen);
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs in_ready=%0b out_valid=%0b required 0 0", in_ready, out_valid);
    end
    checks++;
    if (out_data !== 16'h0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_out data=%h err=%0b required 0000 0", out_data, out_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_table();
    logic [15:0] td [13];
    int          tc [13];
    logic [2:0]  to [13];
    int lat;
    bit rdy;
    exp_t e;
    td = '{16'h00F1, 16'h8001, 16'h0001, 16'h1234, 16'h8000, 16'h8000, 16'h7FFF,
           16'hA5C3, 16'hA5C3, 16'h1234, 16'h0, 16'h0, 16'h0};
    tc = '{4, 1, 1, 8, 15, 15, 3, 0, 1, 8, 0, 0, 0};
    to = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd3, 3'd2, 3'd3, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int k = 10; k < 13; k++) begin
      td[k] = 16'($urandom);
      tc[k] = int'($urandom_range(1, 15));
      to[k] = 3'($urandom_range(0, 4));
    end
    for (int k = 0; k < 13; k++) begin
      send(td[k], tc[k], to[k]);
      wait_out(lat, rdy);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_err !== e.err) begin
        failures++;
        $display("FAIL op_result[%0d] valid=%0b data=%h err=%0b required 1 %h %0b",
                 k, out_valid, out_data, out_err, e.data, e.err);
      end
      checks++;
      if (lat !== e.lat || rdy) begin
        failures++;
        $display("FAIL op_latency[%0d] lat=%0d ready_seen=%0b required %0d 0", k, lat, rdy, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_illegal();
    int lat;
    bit rdy;
    exp_t e;
    send(16'hABCD, 5, 3'b101);
    wait_out(lat, rdy);
    e = sb.pop_front();
    checks++;
    if (out_data !== e.data || out_err !== 1'b1 || lat !== e.lat) begin
      failures++;
      $display("FAIL illegal_op data=%h err=%0b lat=%0d required %h 1 %0d",
               out_data, out_err, lat, e.data, e.lat);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    bit rdy;
    exp_t e;
    send(16'h0F0F, 2, 3'd1);
    wait_out(lat, rdy);
    e = sb.pop_front();
    in_data  = 16'h5555;
    in_cnt   = 4'd1;
    in_op    = 3'd0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] valid=%0b data=%h in_ready=%0b required 1 %h 0",
                 k, out_valid, out_data, in_ready, e.data);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_no_accept valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit rdy;
    exp_t e;
    send(16'h00F1, 4, 3'd0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset valid=%0b data=%h in_ready=%0b required 0 0000 0",
               out_valid, out_data, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_idle in_ready=%0b required 1", in_ready);
    end
    send(16'h0001, 1, 3'd0);
    wait_out(lat, rdy);
    e = sb.pop_front();
    checks++;
    if (out_data !== e.data || out_err !== 1'b0 || lat !== e.lat) begin
      failures++;
      $display("FAIL after_reset data=%h err=%0b lat=%0d required %h 0 %0d",
               out_data, out_err, lat, e.data, e.lat);
    end
    consume();
  endtask

  task automatic test_w32();
    int n;
    int lat;
    int want_lat;
    n = 0;
    while (!in_ready2 && n < 50) begin @(posedge clk); #1; n++; end
    in_data2  = 32'h8000_0000;
    in_cnt2   = 5'd31;
    in_op2    = 3'd1;
    in_valid2 = 1'b1;
    want_lat  = exp_lat(31, 5, 2);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 32'h4000_0000 || out_err2 !== 1'b0) begin
      failures++;
      $display("FAIL w32_rol valid=%0b data=%h err=%0b required 1 40000000 0",
               out_valid2, out_data2, out_err2);
    end
    checks++;
    if (lat !== want_lat) begin
      failures++;
      $display("FAIL w32_latency lat=%0d required %0d", lat, want_lat);
    end
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; in_cnt2 = '0; in_op2 = '0; out_ready2 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_table();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_w32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shifter_seq.md
Name: shifter_seq

Overview:
- Parametrised, multi-cycle logarithmic shifter for WIDTH-bit operands.
- Processes ROWS_PER_CYCLE shift rows per clock, so timing can be traded against latency.
- Sits between the ALU operand registers and the result path, with valid/ready handshakes on both sides.
- Adds rotate-right and an illegal-op flag.

Parameters:
- WIDTH, 16, operand width. Must be a power of 2 and at least 2. Localparam L = log2(WIDTH).
- ROWS_PER_CYCLE, 1, shift rows applied per BUSY cycle. Range 1..L. Localparam G = ceil(L/ROWS_PER_CYCLE).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  WIDTH  operand.
- in_cnt  in  L  shift amount, 0..WIDTH-1.
- in_op  in  3  operation: 000 SLL, 001 ROL, 010 SRL, 011 SRA, 100 ROR, 101-111 illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  result.
- out_err  out  1  the result came from an illegal op.

Behaviour:
- State machine IDLE, BUSY, DONE.
  - Registers: data, cnt, op, group index g (0..G-1), sign bit captured at accept.
- Reset (rst high at an edge):
  - state becomes IDLE; out_data=0, out_valid=0, out_err=0, g=0.
  - in_ready is defined as (state==IDLE) & ~rst, so it is 0 while rst is high.
  - Reset has priority over every event, including mid-BUSY and DONE. An in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1.
  - Accept on in_valid & in_ready: latch in_data, in_cnt, in_op and sign = in_data[WIDTH-1]; set g=0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle applies rows i = g*R .. min(g*R+R, L)-1 in ascending order, where R = ROWS_PER_CYCLE.
  - Row i shifts by 2^i when cnt[i] is 1 and passes the data through otherwise.
  - When g==G-1, go to DONE with the registered result; otherwise g increments.
- Fill rules:
  - SLL: zeros in at the LSBs.
  - ROL: MSBs wrap to the LSBs.
  - SRL: zeros in at the MSBs.
  - SRA: the latched sign bit fills the MSBs.
  - ROR: LSBs wrap to the MSBs.
- Illegal op: every row passes the data through, so out_data equals the accepted in_data and out_err=1. Legal ops give out_err=0.
- DONE:
  - out_valid=1; out_data and out_err stay stable while out_ready=0.
  - On out_ready, go to IDLE next cycle and drop out_valid. in_ready rises in that IDLE cycle; there is no same-cycle re-accept.
- Latency: accept at edge 0 gives out_valid high after edge G+1. With WIDTH=16 and R=1 that is 5 cycles; with R=4 it is 2 cycles.
- cnt=0: all rows pass; latency is unchanged unless the optional feature is enabled.
- in_valid in BUSY or DONE is ignored; the upstream holds its data until in_ready.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SHIFTER_EARLY_DONE_EN.
- When defined:
  - At accept with in_cnt==0, go directly to DONE (latency 1).
  - In BUSY, after applying group g, go to DONE if all cnt bits above the last applied row are zero.
  - Results are identical to the plain build; only latency shrinks.
- When undefined: fixed latency of G+1 for every operation.

Test Plan:
- WIDTH=16, R=1:
  - SLL 0x00F1, cnt 4 -> out_data 0x0F10, out_err 0. out_valid first high 5 cycles after accept; in_ready low throughout.
  - ROL 0x8001, cnt 1 -> 0x0003. ROR 0x0001, cnt 1 -> 0x8000. ROR 0x1234, cnt 8 -> 0x3412.
  - SRA 0x8000, cnt 15 -> 0xFFFF. SRL 0x8000, cnt 15 -> 0x0001. SRA 0x7FFF, cnt 3 -> 0x0FFF.
  - op 101, data 0xABCD, cnt 5 -> out_data 0xABCD, out_err 1.
  - Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 -> out_data stable, in_ready 0, no second accept. Release out_ready -> out_valid low next cycle, in_ready 1.
  - Reset in the 2nd BUSY cycle -> IDLE after the edge, out_valid 0, out_data 0. A new SLL 0x0001, cnt 1 then returns 0x0002.
- WIDTH=32, R=2 (G=3):
  - ROL 0x80000000, cnt 31 -> 0x40000000, latency 4.
- With SHIFTER_EARLY_DONE_EN, WIDTH=16, R=1:
  - cnt 0 -> latency 1, data unchanged.
  - cnt 1 -> latency 2.
  - cnt 8 -> latency 5.
